// File: rtl/isl58x_stream_sequencer.sv
// ISL58315 laser-driver sequencer: timed LOWP/CE power sequencing, divided driver
// clock and valid/ready streaming of 15-bit drive words with underrun blanking.
module isl58x_stream_sequencer #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned WAKE_CYCLES = 1000,
    parameter int unsigned LINE_LEN    = 640,
    parameter logic [14:0] BLANK_WORD  = 15'h0000
) (
    input  logic        clk_i,
    input  logic        async_rst_i,
    input  logic        enable_i,
    input  logic        rtz_mode_i,
    input  logic [14:0] pix_data_i,
    input  logic        pix_valid_i,
    output logic        pix_ready_o,
    output logic        line_done_o,
    output logic        underrun_o,
    input  logic        underrun_clr_i,
    output logic        running_o,
    output logic [14:0] isl58x_D,
    output logic        isl58x_CLK,
    output logic        isl58x_RTZ,
    output logic        isl58x_LOWP,
    output logic        isl58x_CE
);
    // state | meaning
    // OFF   | driver in low power, CE low, clock parked, RTZ follows rtz_mode_i
    // WAKE  | LOWP released, waiting WAKE_CYCLES before enabling the chip
    // RUN   | CE high, streaming words from the pixel source
    // DRAIN | CE high, blanking out the rest of the current line before OFF
    typedef enum logic [1:0] {ST_OFF, ST_WAKE, ST_RUN, ST_DRAIN} state_t;

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam int WORD_W = $clog2(LINE_LEN);
    localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [WAKE_W-1:0] WAKE_MAX = WAKE_W'(WAKE_CYCLES - 1);
    localparam logic [WORD_W-1:0] WORD_MAX = WORD_W'(LINE_LEN - 1);

    state_t             state_q, state_d;
    logic [WAKE_W-1:0]  wake_q, wake_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [WORD_W-1:0]  word_q, word_d, word_next;
    logic [14:0]        hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [14:0]        d_q, d_d;
    logic               clk_q, clk_d;
    logic               rtz_q, rtz_d;
    logic               lowp_q, lowp_d;
    logic               active_q, active_d;
    logic               line_done_q, line_done_d;
    logic               underrun_q, underrun_d;
    logic               div_end, update_tick, last_word, pix_xfer;

    assign div_end     = (div_q == DIV_MAX);
    assign update_tick = div_end && clk_q;
    assign last_word   = (word_q == WORD_MAX);
    assign word_next   = last_word ? '0 : word_q + 1'b1;
    assign pix_ready_o = (state_q == ST_RUN) && !hold_full_q;
    assign pix_xfer    = pix_valid_i && pix_ready_o;

    always_comb begin
        state_d     = state_q;
        wake_d      = wake_q;
        div_d       = div_q;
        clk_d       = clk_q;
        word_d      = word_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        d_d         = d_q;
        rtz_d       = rtz_q;
        line_done_d = 1'b0;
        // a set later in this block overrides the clear
        underrun_d  = underrun_q && !underrun_clr_i;

        case (state_q)
            ST_OFF: begin
                rtz_d       = rtz_mode_i;
                d_d         = BLANK_WORD;
                clk_d       = 1'b0;
                div_d       = '0;
                word_d      = '0;
                wake_d      = '0;
                hold_full_d = 1'b0;
                if (enable_i) state_d = ST_WAKE;
            end
            ST_WAKE: begin
                if (!enable_i) begin
                    state_d = ST_OFF;
                    wake_d  = '0;
                end else if (wake_q == WAKE_MAX) begin
                    state_d = ST_RUN;
                    wake_d  = '0;
                    div_d   = '0;
                    clk_d   = 1'b0;
                end else begin
                    wake_d = wake_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (pix_xfer) begin
                    hold_d      = pix_data_i;
                    hold_full_d = 1'b1;
                end
                div_d = div_end ? '0 : div_q + 1'b1;
                if (div_end) clk_d = ~clk_q;
                if (update_tick) begin
                    word_d      = word_next;
                    line_done_d = last_word;
                    if (hold_full_q) begin
                        d_d         = hold_q;
                        hold_full_d = 1'b0;
                    end else begin
                        d_d        = BLANK_WORD;
                        underrun_d = 1'b1;
                    end
                end
                if (!enable_i) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                hold_full_d = 1'b0;
                div_d = div_end ? '0 : div_q + 1'b1;
                if (div_end) clk_d = ~clk_q;
                if (update_tick) begin
                    d_d         = BLANK_WORD;
                    word_d      = word_next;
                    line_done_d = last_word;
                end
                // line boundary reached (or never left): park the clock and power down
                if ((word_q == '0) || (update_tick && last_word)) begin
                    state_d = ST_OFF;
                    div_d   = '0;
                    clk_d   = 1'b0;
                    word_d  = '0;
                    d_d     = BLANK_WORD;
                end
            end
            default: state_d = ST_OFF;
        endcase

        lowp_d   = (state_d == ST_OFF);
        active_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    end

    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i) begin
            state_q     <= ST_OFF;
            wake_q      <= '0;
            div_q       <= '0;
            word_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            d_q         <= '0;
            clk_q       <= 1'b0;
            rtz_q       <= 1'b0;
            lowp_q      <= 1'b1;
            active_q    <= 1'b0;
            line_done_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wake_q      <= wake_d;
            div_q       <= div_d;
            word_q      <= word_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            d_q         <= d_d;
            clk_q       <= clk_d;
            rtz_q       <= rtz_d;
            lowp_q      <= lowp_d;
            active_q    <= active_d;
            line_done_q <= line_done_d;
            underrun_q  <= underrun_d;
        end
    end

    assign isl58x_D    = d_q;
    assign isl58x_CLK  = clk_q;
    assign isl58x_RTZ  = rtz_q;
    assign isl58x_LOWP = lowp_q;
    assign isl58x_CE   = active_q;
    assign running_o   = active_q;
    assign line_done_o = line_done_q;
    assign underrun_o  = underrun_q;
endmodule

// File: tb/tb_isl58x_stream_sequencer.sv
// Directed bench for isl58x_stream_sequencer: a cycle-checkpoint vector table for
// power-up/stream/underrun/drain, plus hand sequences for WAKE abort and reset.
module tb_isl58x_stream_sequencer;
    logic        clk_i = 1'b0;
    logic        async_rst_i = 1'b0;
    logic        enable_i = 1'b0;
    logic        rtz_mode_i = 1'b0;
    logic [14:0] pix_data_i = 15'h0001;
    logic        pix_valid_i = 1'b0;
    logic        underrun_clr_i = 1'b0;
    logic        pix_ready_o, line_done_o, underrun_o, running_o;
    logic [14:0] isl58x_D;
    logic        isl58x_CLK, isl58x_RTZ, isl58x_LOWP, isl58x_CE;

    int n_checks = 0;
    int n_fail   = 0;

    isl58x_stream_sequencer #(
        .CLK_DIV(2), .WAKE_CYCLES(10), .LINE_LEN(4), .BLANK_WORD(15'h0000)
    ) dut (
        .clk_i(clk_i), .async_rst_i(async_rst_i), .enable_i(enable_i),
        .rtz_mode_i(rtz_mode_i), .pix_data_i(pix_data_i), .pix_valid_i(pix_valid_i),
        .pix_ready_o(pix_ready_o), .line_done_o(line_done_o), .underrun_o(underrun_o),
        .underrun_clr_i(underrun_clr_i), .running_o(running_o), .isl58x_D(isl58x_D),
        .isl58x_CLK(isl58x_CLK), .isl58x_RTZ(isl58x_RTZ), .isl58x_LOWP(isl58x_LOWP),
        .isl58x_CE(isl58x_CE)
    );

    always #5 clk_i = ~clk_i;

    // observed bundle: {D, CLK, LOWP, CE, RTZ, ready, line_done, underrun, running}
    logic [22:0] obs;
    assign obs = {isl58x_D, isl58x_CLK, isl58x_LOWP, isl58x_CE, isl58x_RTZ,
                  pix_ready_o, line_done_o, underrun_o, running_o};

    typedef struct {
        int          n;   // clk_i edges to advance
        logic [3:0]  in;  // {enable, rtz_mode, pix_valid, underrun_clr}
        logic [14:0] d;
        logic [7:0]  o;   // {CLK, LOWP, CE, RTZ, ready, line_done, underrun, running}
    } vec_t;

    vec_t vecs [26];

    function automatic vec_t mk(int n, logic [3:0] in, logic [14:0] d, logic [7:0] o);
        vec_t v;
        v.n = n; v.in = in; v.d = d; v.o = o;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one clk_i edge; the source presents the next word after each accepted one
    task automatic tick();
        logic x;
        x = pix_valid_i && pix_ready_o;
        @(posedge clk_i);
        #1;
        if (x) pix_data_i = pix_data_i + 15'd1;
    endtask

    initial begin
        int  cnt;
        logic ce_seen;

        vecs[0]  = mk(1,  4'b0100, 15'h0000, 8'b0101_0000); // OFF after reset, RTZ sampled
        vecs[1]  = mk(1,  4'b1100, 15'h0000, 8'b0001_0000); // enable -> WAKE, LOWP falls
        vecs[2]  = mk(9,  4'b1000, 15'h0000, 8'b0001_0000); // still WAKE, RTZ static
        vecs[3]  = mk(1,  4'b1010, 15'h0000, 8'b0011_1001); // RUN, CE high
        vecs[4]  = mk(1,  4'b1010, 15'h0000, 8'b0011_0001); // word 1 in hold
        vecs[5]  = mk(1,  4'b1010, 15'h0000, 8'b1011_0001); // first rise samples blank
        vecs[6]  = mk(2,  4'b1010, 15'h0001, 8'b0011_1001); // first update
        vecs[7]  = mk(2,  4'b1010, 15'h0001, 8'b1011_0001); // D stable at rise
        vecs[8]  = mk(2,  4'b1010, 15'h0002, 8'b0011_1001);
        vecs[9]  = mk(4,  4'b1010, 15'h0003, 8'b0011_1001);
        vecs[10] = mk(4,  4'b1010, 15'h0004, 8'b0011_1101); // end of line 1
        vecs[11] = mk(1,  4'b1010, 15'h0004, 8'b0011_0001); // pulse is one cycle
        vecs[12] = mk(3,  4'b1010, 15'h0005, 8'b0011_1001);
        vecs[13] = mk(12, 4'b1010, 15'h0008, 8'b0011_1101); // end of line 2
        vecs[14] = mk(4,  4'b1000, 15'h0000, 8'b0011_1011); // underrun: blank word
        vecs[15] = mk(4,  4'b1010, 15'h0009, 8'b0011_1011); // one period only, sticky
        vecs[16] = mk(1,  4'b1011, 15'h0009, 8'b0011_0001); // clear
        vecs[17] = mk(3,  4'b1000, 15'h000A, 8'b0011_1001);
        vecs[18] = mk(3,  4'b1000, 15'h000A, 8'b1011_1001); // hold empty at rise
        vecs[19] = mk(1,  4'b1010, 15'h0000, 8'b0011_0111); // transfer on update tick
        vecs[20] = mk(4,  4'b1010, 15'h000B, 8'b0011_1011); // loaded word follows
        vecs[21] = mk(4,  4'b1001, 15'h0000, 8'b0011_1011); // clear vs set: set wins
        vecs[22] = mk(1,  4'b0010, 15'h0000, 8'b0011_0011); // disable -> DRAIN
        vecs[23] = mk(3,  4'b0000, 15'h0000, 8'b0011_0011); // word 3 blank, hold dropped
        vecs[24] = mk(4,  4'b0000, 15'h0000, 8'b0101_0110); // word 4 blank -> OFF
        vecs[25] = mk(1,  4'b0000, 15'h0000, 8'b0100_0010); // OFF, RTZ resampled

        // reset held with inputs toggling
        enable_i = 1'b1; rtz_mode_i = 1'b1; pix_valid_i = 1'b1; pix_data_i = 15'h0007;
        tick();
        enable_i = 1'b0; rtz_mode_i = 1'b0; pix_valid_i = 1'b0; underrun_clr_i = 1'b1;
        tick();
        check("reset_state", 32'(obs), 32'({15'h0000, 8'b0100_0000}));

        enable_i = 1'b0; rtz_mode_i = 1'b1; pix_valid_i = 1'b0; underrun_clr_i = 1'b0;
        pix_data_i = 15'h0001;
        async_rst_i = 1'b1;

        for (int i = 0; i < 26; i++) begin
            {enable_i, rtz_mode_i, pix_valid_i, underrun_clr_i} = vecs[i].in;
            repeat (vecs[i].n) tick();
            check($sformatf("vec[%0d]", i), 32'(obs), 32'({vecs[i].d, vecs[i].o}));
        end

        // disable during WAKE
        underrun_clr_i = 1'b1;
        tick();
        underrun_clr_i = 1'b0;
        check("underrun_cleared", 32'(underrun_o), 32'd0);
        enable_i = 1'b1;
        repeat (3) tick();
        check("wake_lowp_ce", 32'({isl58x_LOWP, isl58x_CE}), 32'b00);
        enable_i = 1'b0;
        tick();
        check("wake_abort_off", 32'({isl58x_LOWP, isl58x_CE, running_o}), 32'b100);
        ce_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (isl58x_CE) ce_seen = 1'b1;
        end
        check("wake_abort_no_ce", 32'(ce_seen), 32'd0);

        // reset mid-RUN with CLK high
        enable_i = 1'b1;
        cnt = 0;
        while (isl58x_CLK !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        check("run_clk_high_reached", 32'(isl58x_CLK), 32'd1);
        #2;
        async_rst_i = 1'b0;
        #1;
        check("async_reset_immediate", 32'(obs), 32'({15'h0000, 8'b0100_0000}));
        #1;
        async_rst_i = 1'b1;
        tick();
        check("rewake_lowp", 32'({isl58x_LOWP, isl58x_CE}), 32'b00);
        cnt = 0;
        while (isl58x_CE !== 1'b1 && cnt < 30) begin
            tick();
            cnt++;
        end
        check("rewake_full_wake_len", 32'(cnt), 32'd10);

        // disable right at RUN entry: word counter 0, DRAIN exits next cycle
        enable_i = 1'b0;
        tick();
        check("drain_word0_entry", 32'({running_o, isl58x_CE, pix_ready_o}), 32'b110);
        tick();
        check("drain_word0_off", 32'({running_o, isl58x_CE, isl58x_LOWP, isl58x_CLK}), 32'b0010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
